gear_selector: RTL

- Shift-lever controller that sits directly upstream of the vehicle physics/RPM stage.
- Converts raw push-button lever inputs into the gear code (3:P, 6:R, 9:N, 12:D), the low-gear-mode flag and the max-gear limit consumed downstream.
- Enforces brake, speed and engine interlocks. Flags every rejected request with a one-cycle pulse for the buzzer/dashboard.

---
 rtl/gear_selector_if.sv | 27 ++
 rtl/gear_selector.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gear_selector_if.sv
// rtl/gear_selector_if.sv - lever inputs, interlock inputs and gear outputs of gear_selector
interface gear_selector_if;
  logic       i_engine_on;
  logic [7:0] i_speed;
  logic       i_is_brake;
  logic       i_btn_up;
  logic       i_btn_down;
  logic       i_btn_low;
  logic       i_btn_plus;
  logic       i_btn_minus;
  logic [3:0] o_current_gear;
  logic       o_is_low_gear_mode;
  logic [2:0] o_max_gear_limit;
  logic       o_shift_reject;

  modport master (
    output i_engine_on, i_speed, i_is_brake,
    output i_btn_up, i_btn_down, i_btn_low, i_btn_plus, i_btn_minus,
    input  o_current_gear, o_is_low_gear_mode, o_max_gear_limit, o_shift_reject
  );

  modport slave (
    input  i_engine_on, i_speed, i_is_brake,
    input  i_btn_up, i_btn_down, i_btn_low, i_btn_plus, i_btn_minus,
    output o_current_gear, o_is_low_gear_mode, o_max_gear_limit, o_shift_reject
  );
endinterface

// File: rtl/gear_selector.sv
// rtl/gear_selector.sv - debounced shift lever with P/R/N/D interlocks and low-gear limit control
module gear_selector #(
  parameter int              DB_W            = 20,
  parameter logic [DB_W-1:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]      LIM1_SPD        = 8'd35,
  parameter logic [7:0]      LIM2_SPD        = 8'd65,
  parameter logic [7:0]      LIM3_SPD        = 8'd95
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  gear_selector_if.slave  io
);

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LOW   = 2;
  localparam int BTN_PLUS  = 3;
  localparam int BTN_MINUS = 4;

  typedef enum logic [3:0] {
    ST_P = 4'd3,
    ST_R = 4'd6,
    ST_N = 4'd9,
    ST_D = 4'd12
  } gear_e;

  logic [4:0]      w_raw;
  logic [4:0]      r_sync1, r_sync2, r_db, r_db_q, r_armed, r_press;
  logic [DB_W-1:0] r_cnt [5];
  logic [1:0]      r_vld;

  assign w_raw = {io.i_btn_minus, io.i_btn_plus, io.i_btn_low, io.i_btn_down, io.i_btn_up};

  // A button only arms once it has been seen released after reset, so a lever
  // held through reset cannot fire a press when reset lifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      r_armed <= '0;
      r_press <= '0;
      r_vld   <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q & r_armed;
      r_armed <= r_armed | ({5{r_vld[1]}} & ~r_sync2 & ~r_db);
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEBOUNCE_CYCLES - 1'b1) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  gear_e      r_gear, w_gear_nxt;
  logic       r_low, w_low_nxt;
  logic [2:0] r_lim, w_lim_nxt;
  logic       r_rej, w_rej_nxt;
  logic       w_spd0, w_park, w_pr_ok;
  logic [2:0] w_lim_tgt;
  logic [7:0] w_tgt_spd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gear <= ST_P;
      r_low  <= 1'b0;
      r_lim  <= 3'd6;
      r_rej  <= 1'b0;
    end else begin
      r_gear <= w_gear_nxt;
      r_low  <= w_low_nxt;
      r_lim  <= w_lim_nxt;
      r_rej  <= w_rej_nxt;
    end
  end

  always_comb begin
    w_gear_nxt = r_gear;
    w_low_nxt  = r_low;
    w_lim_nxt  = r_lim;
    w_rej_nxt  = 1'b0;
    w_spd0     = (io.i_speed == 8'd0);
    w_park     = ~io.i_engine_on & w_spd0;
    w_pr_ok    = io.i_engine_on & io.i_is_brake & w_spd0;
    w_lim_tgt  = r_press[BTN_PLUS] ? r_lim + 3'd1 : r_lim - 3'd1;
    w_tgt_spd  = (w_lim_tgt == 3'd1) ? LIM1_SPD :
                 (w_lim_tgt == 3'd2) ? LIM2_SPD : LIM3_SPD;

    if (w_park) begin
      w_gear_nxt = ST_P;
      w_low_nxt  = 1'b0;
      w_lim_nxt  = 3'd6;
    end else if (r_press[BTN_UP] | r_press[BTN_DOWN]) begin
      if (r_press[BTN_UP] & r_press[BTN_DOWN]) begin
        w_rej_nxt = 1'b1;
      end else if (r_press[BTN_DOWN]) begin
        case (r_gear)
          ST_P:    if (w_pr_ok) w_gear_nxt = ST_R; else w_rej_nxt = 1'b1;
          ST_R:    w_gear_nxt = ST_N;
          ST_N:    if (io.i_engine_on) w_gear_nxt = ST_D; else w_rej_nxt = 1'b1;
          default: w_rej_nxt = 1'b1;
        endcase
      end else begin
        case (r_gear)
          ST_P:    w_rej_nxt = 1'b1;
          ST_R:    if (w_spd0) w_gear_nxt = ST_P; else w_rej_nxt = 1'b1;
          ST_N:    if (w_pr_ok) w_gear_nxt = ST_R; else w_rej_nxt = 1'b1;
          default: begin
            w_gear_nxt = ST_N;
            w_low_nxt  = 1'b0;
            w_lim_nxt  = 3'd6;
          end
        endcase
      end
    end else if (r_press[BTN_LOW]) begin
      if (r_gear != ST_D) begin
        w_rej_nxt = 1'b1;
      end else if (r_low) begin
        w_low_nxt = 1'b0;
        w_lim_nxt = 3'd6;
      end else if (io.i_speed <= LIM3_SPD) begin
        w_low_nxt = 1'b1;
        w_lim_nxt = 3'd3;
      end else begin
        w_rej_nxt = 1'b1;
      end
    end else if (r_press[BTN_PLUS] | r_press[BTN_MINUS]) begin
      // Simultaneous plus and minus is ambiguous and refused like up+down.
      if ((r_press[BTN_PLUS] & r_press[BTN_MINUS]) | ~r_low) w_rej_nxt = 1'b1;
      else if (r_press[BTN_PLUS] && r_lim == 3'd3)           w_rej_nxt = 1'b1;
      else if (r_press[BTN_MINUS] && r_lim == 3'd1)          w_rej_nxt = 1'b1;
      else if (io.i_speed > w_tgt_spd)                       w_rej_nxt = 1'b1;
      else                                                   w_lim_nxt = w_lim_tgt;
    end
  end

  assign io.o_current_gear     = r_gear;
  assign io.o_is_low_gear_mode = r_low;
  assign io.o_max_gear_limit   = r_lim;
  assign io.o_shift_reject     = r_rej;

endmodule
